fetch_pc: RTL and testbench

Fetch-stage program counter for the five-stage MIPS pipeline. It holds the PC of the instruction being fetched and selects the next PC. Inputs are the ID-stage branch decision (`branchEn` from the comparator), jump targets, the stall signal and CP0 exception/eret redirects. It also flags fetch address errors (AdEL) and marks delay-slot instructions for precise exceptions.

---
 rtl/fetch_pc.sv | 87 ++++++++
 tb/tb_fetch_pc.sv | 154 +++++++++++++++
 2 files changed

// File: rtl/fetch_pc.sv
// Fetch-stage program counter: selects the next fetch address from exception,
// eret, stall, branch and jump sources; flags AdEL and delay-slot fetches.
module fetch_pc #(
  parameter logic [31:0] RESET_PC   = 32'h0000_3000,
  parameter logic [31:0] HANDLER_PC = 32'h0000_4180,
  parameter logic [31:0] IM_BASE    = 32'h0000_3000,
  parameter logic [31:0] IM_END     = 32'h0000_6FFF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall,
  input  logic [2:0]  npcOp,
  input  logic        branchEn,
  input  logic [31:0] pcD,
  input  logic [15:0] imm16,
  input  logic [25:0] instrIndex,
  input  logic [31:0] regTarget,
  input  logic        excReq,
  input  logic        eretReq,
  input  logic [31:0] epc,
  output logic [31:0] pcF,
  output logic        bdF,
  output logic [4:0]  excCodeF,
  output logic        flushD
);

  localparam int unsigned AW  = 32;
  localparam int unsigned ECW = 5;

  localparam logic [2:0] OP_BRANCH = 3'd1;
  localparam logic [2:0] OP_JUMP   = 3'd2;
  localparam logic [2:0] OP_JREG   = 3'd3;

  localparam logic [ECW-1:0] EXC_ADEL = ECW'(4);
  localparam logic [ECW-1:0] EXC_NONE = ECW'(0);

  logic [AW-1:0] pc_q;
  logic [AW-1:0] pc_d;
  logic [AW-1:0] seq_pc;
  logic [AW-1:0] br_target;
  logic [AW-1:0] j_target;
  logic          is_ctrl;
  logic          adel;

  assign seq_pc    = pc_q + AW'(4);
  assign br_target = pcD + AW'(4) + {{14{imm16[15]}}, imm16, 2'b00};
  assign j_target  = {pcD[31:28], instrIndex, 2'b00};
  assign is_ctrl   = (npcOp == OP_BRANCH) || (npcOp == OP_JUMP) || (npcOp == OP_JREG);

  // Next-PC priority: exception > eret > stall > branch/jump > sequential
  always_comb begin
    pc_d = seq_pc;
    if (excReq) begin
      pc_d = HANDLER_PC;
    end else if (eretReq) begin
      pc_d = epc;
    end else if (stall) begin
      pc_d = pc_q;
    end else begin
      unique case (npcOp)
        OP_BRANCH: pc_d = branchEn ? br_target : seq_pc;
        OP_JUMP:   pc_d = j_target;
        OP_JREG:   pc_d = regTarget;
        default:   pc_d = seq_pc;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pc_q <= RESET_PC;
    end else begin
      pc_q <= pc_d;
    end
  end

  // Delay slot always executes, so bdF ignores branchEn
  assign bdF = is_ctrl && !stall && !excReq && !eretReq;

  // eret has no delay slot; on exceptions CP0 performs its own flush
  assign flushD = eretReq && !excReq;

  assign adel     = (pc_q[1:0] != 2'b00) || (pc_q < IM_BASE) || (pc_q > IM_END);
  assign excCodeF = adel ? EXC_ADEL : EXC_NONE;
  assign pcF      = pc_q;

endmodule

// File: tb/tb_fetch_pc.sv
// Directed self-checking bench for fetch_pc.
module tb_fetch_pc;

  logic        clk;
  logic        reset;
  logic        stall;
  logic [2:0]  npcOp;
  logic        branchEn;
  logic [31:0] pcD;
  logic [15:0] imm16;
  logic [25:0] instrIndex;
  logic [31:0] regTarget;
  logic        excReq;
  logic        eretReq;
  logic [31:0] epc;
  logic [31:0] pcF;
  logic        bdF;
  logic [4:0]  excCodeF;
  logic        flushD;

  int n_chk  = 0;
  int n_pass = 0;

  fetch_pc dut (
    .clk        (clk),
    .reset      (reset),
    .stall      (stall),
    .npcOp      (npcOp),
    .branchEn   (branchEn),
    .pcD        (pcD),
    .imm16      (imm16),
    .instrIndex (instrIndex),
    .regTarget  (regTarget),
    .excReq     (excReq),
    .eretReq    (eretReq),
    .epc        (epc),
    .pcF        (pcF),
    .bdF        (bdF),
    .excCodeF   (excCodeF),
    .flushD     (flushD)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    stall = 1'b0; npcOp = 3'd0; branchEn = 1'b0;
    excReq = 1'b0; eretReq = 1'b0;
  endtask

  initial begin
    reset = 1'b0; idle();
    pcD = '0; imm16 = '0; instrIndex = '0; regTarget = '0; epc = '0;

    // Reset holds RESET_PC
    step(); step();
    check("rst_pc", pcF, 32'h3000);
    check("rst_exc", 32'(excCodeF), 32'd0);
    check("rst_bd", 32'(bdF), 32'd0);
    check("rst_flush", 32'(flushD), 32'd0);

    // Sequential fetch
    reset = 1'b1;
    #1 check("rel_pc", pcF, 32'h3000);
    step(); check("seq1", pcF, 32'h3004);
    step(); check("seq2", pcF, 32'h3008);
    check("seq2_exc", 32'(excCodeF), 32'd0);
    step(); check("seq3", pcF, 32'h300C);

    // Taken branch with offset -1 word: 3004 + 4 - 4
    pcD = 32'h3004; npcOp = 3'd1; imm16 = 16'hFFFF; branchEn = 1'b1;
    #1 check("br_taken_bd", 32'(bdF), 32'd1);
    step(); check("br_taken_pc", pcF, 32'h3004);
    idle();
    step(); check("seq4", pcF, 32'h3008);

    // Untaken branch still marks a delay slot
    npcOp = 3'd1; branchEn = 1'b0;
    #1 check("br_nt_bd", 32'(bdF), 32'd1);
    step(); check("br_nt_pc", pcF, 32'h300C);

    // j: {pcD[31:28], 26'hD00, 2'b00}
    pcD = 32'h3010; npcOp = 3'd2; instrIndex = 26'h0000D00;
    step(); check("j_pc", pcF, 32'h0000_3400);
    check("j_exc", 32'(excCodeF), 32'd0);

    // jr to a misaligned target -> AdEL
    npcOp = 3'd3; regTarget = 32'h3102;
    step(); check("jr_pc", pcF, 32'h3102);
    check("jr_misalign_exc", 32'(excCodeF), 32'd4);

    // Range boundaries of the instruction memory
    regTarget = 32'h6FFC; step(); check("top_ok_exc", 32'(excCodeF), 32'd0);
    regTarget = 32'h7000; step(); check("above_exc", 32'(excCodeF), 32'd4);
    regTarget = 32'h2FFC; step(); check("below_exc", 32'(excCodeF), 32'd4);
    regTarget = 32'h3000; step(); check("base_ok_exc", 32'(excCodeF), 32'd0);
    regTarget = 32'h3100; step(); check("jr_3100", pcF, 32'h3100);

    // Stall suppresses the branch and the delay-slot mark
    stall = 1'b1; npcOp = 3'd1; branchEn = 1'b1; pcD = 32'h3004; imm16 = 16'hFFFF;
    #1 check("stall_bd", 32'(bdF), 32'd0);
    step(); check("stall_hold1", pcF, 32'h3100);
    step(); check("stall_hold2", pcF, 32'h3100);
    step(); check("stall_hold3", pcF, 32'h3100);

    // Exception overrides stall
    excReq = 1'b1;
    #1 check("exc_bd", 32'(bdF), 32'd0);
    check("exc_flush", 32'(flushD), 32'd0);
    step(); check("exc_pc", pcF, 32'h4180);

    // eret overrides a jump, flushes D, no delay slot
    idle(); eretReq = 1'b1; epc = 32'h3020; npcOp = 3'd2;
    #1 check("eret_flush", 32'(flushD), 32'd1);
    check("eret_bd", 32'(bdF), 32'd0);
    step(); check("eret_pc", pcF, 32'h3020);

    // Exception beats eret
    excReq = 1'b1;
    #1 check("exc_eret_flush", 32'(flushD), 32'd0);
    step(); check("exc_eret_pc", pcF, 32'h4180);

    // npcOp 4..7 behave as sequential
    idle(); npcOp = 3'd5;
    #1 check("op5_bd", 32'(bdF), 32'd0);
    step(); check("op5_pc", pcF, 32'h4184);

    // Async reset between edges drops an in-flight redirect
    idle(); npcOp = 3'd3; regTarget = 32'h3040;
    step(); check("pre_rst_pc", pcF, 32'h3040);
    regTarget = 32'h5000;
    @(negedge clk);
    reset = 1'b0;
    #1 check("async_rst_pc", pcF, 32'h3000);
    step(); check("rst_hold_pc", pcF, 32'h3000);
    idle(); reset = 1'b1;
    step(); check("post_rst_seq", pcF, 32'h3004);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
